// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: cache handshake, load align/extend, ALU pass-through, one-cycle writeback record.
// ALU/misaligned ops retire next cycle. Memory ops hold in_ready low until the cycle after data_resp.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        in_ready,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_addr,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t      state;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        is_load;
  logic        is_mem;
  logic        mis;
  logic [1:0]  off;
  logic [3:0]  mbe;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign in_ready = (state == IDLE);
  assign accept   = ex_valid & in_ready & ~flush;
  assign off      = ex_alu_out[1:0];
  assign is_load  = (ex_op == OP_LOAD);
  assign is_mem   = is_load | (ex_op == OP_STORE);
  assign wdata    = ex_rs2 << {off, 3'b000};

  // Width class from funct3[1:0]; reserved encodings fall into the word class.
  always_comb begin
    mbe = 4'b1111;
    mis = 1'b0;
    case (ex_funct3[1:0])
      2'b00:   mbe = 4'b0001 << off;
      2'b01: begin
        mbe = 4'b0011 << off;
        mis = off[0];
      end
      default: mis = (off != 2'b00);
    endcase
  end

  assign lane = data_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = data_rdata;
    case (funct3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'b0, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'b0, lane[15:0]};
      default: load_val = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_read  <= 1'b0;
      data_write <= 1'b0;
      data_addr  <= '0;
      data_mbe   <= '0;
      data_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign   <= 1'b0;
      load_q     <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      rd_q       <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_out;
            end else if (mis) begin
              wb_valid <= 1'b1;
              wb_rd    <= '0;
              wb_data  <= '0;
              misalign <= 1'b1;
            end else begin
              state      <= BUSY;
              data_read  <= is_load;
              data_write <= ~is_load;
              data_addr  <= {ex_alu_out[31:2], 2'b00};
              data_mbe   <= mbe;
              data_wdata <= wdata;
              load_q     <= is_load;
              funct3_q   <= ex_funct3;
              off_q      <= off;
              rd_q       <= ex_rd;
            end
          end
        end
        BUSY: begin
          // flush is deliberately ignored here: the outstanding access must complete.
          if (data_resp) begin
            state      <= IDLE;
            data_read  <= 1'b0;
            data_write <= 1'b0;
            wb_valid   <= 1'b1;
            wb_rd      <= load_q ? rd_q : 5'd0;
            wb_data    <= load_q ? load_val : 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte-array memory model, randomized cache latency.
module tb_mem_access_stage;
  logic        clk, rst_n, ex_valid, flush;
  logic [1:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_rs2;
  logic [4:0]  ex_rd;
  logic        in_ready, data_read, data_write, data_resp;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_mbe;
  logic        wb_valid, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .in_ready(in_ready), .data_read(data_read), .data_write(data_write),
    .data_addr(data_addr), .data_mbe(data_mbe), .data_wdata(data_wdata),
    .data_resp(data_resp), .data_rdata(data_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; logic mis; } wb_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] mbe; logic [31:0] wdata; } req_t;

  wb_t   exp_q[$];
  req_t  req_q[$];
  logic [7:0] mem_b [0:255];
  int    checks = 0, errors = 0;
  int    resp_delay = -1;
  bit    auto_resp = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] b);
    int w = width_of(f3);
    logic [31:0] v = 0;
    for (int i = 0; i < w; i++) v = v | (32'(mem_b[b + 8'(i)]) << (8 * i));
    if (w < 4 && !f3[2] && v[8*w-1]) v = v | ~((32'd1 << (8 * w)) - 32'd1);
    return v;
  endfunction

  // Drives one instruction when the stage is ready and records what must come back.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic fl);
    int n = 0;
    int w, off;
    logic mem, mis;
    wb_t e;
    req_t r;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", {127'b0, in_ready}, 128'd1);
    w   = width_of(f3);
    off = int'(a[1:0]);
    mem = (op == 2'b01) || (op == 2'b10);
    mis = (w == 2 && a[0]) || (w == 4 && a[1:0] != 2'b00);
    ex_op = op; ex_funct3 = f3; ex_alu_out = a; ex_rs2 = rs2; ex_rd = rd;
    flush = fl; ex_valid = 1'b1;
    if (!fl) begin
      if (!mem) begin
        e.rd = rd; e.data = a; e.mis = 1'b0; exp_q.push_back(e);
      end else if (mis) begin
        e.rd = 0; e.data = 0; e.mis = 1'b1; exp_q.push_back(e);
      end else begin
        r.wr    = (op == 2'b10);
        r.addr  = a & ~32'd3;
        r.mbe   = 4'(((1 << w) - 1) << off);
        r.wdata = rs2 * (32'd1 << (8 * off));
        req_q.push_back(r);
        if (op == 2'b01) begin
          e.rd = rd; e.data = model_load(f3, a[7:0]);
        end else begin
          e.rd = 0; e.data = 0;
          for (int i = 0; i < w; i++) mem_b[a[7:0] + 8'(i)] = 8'(rs2 >> (8 * i));
        end
        e.mis = 1'b0;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
    if (fl)
      chk("flush_no_accept", {125'b0, wb_valid, data_read, data_write}, 128'd0);
    else if (!mem || mis)
      chk("retire_next_cycle", {124'b0, wb_valid, data_read, data_write, in_ready}, 128'b1001);
    else
      chk("request_start", {124'b0, wb_valid, data_read, data_write, in_ready},
          {124'b0, 1'b0, op == 2'b01, op == 2'b10, 1'b0});
  endtask

  // Cache responder: checks each request, holds it for a delay, then returns model memory.
  initial begin
    int d;
    req_t r;
    logic [127:0] held;
    logic [7:0] b;
    data_resp = 1'b0; data_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (auto_resp && rst_n && (data_read || data_write)) begin
        if (req_q.size() == 0) begin
          chk("unexpected_request", {127'b0, data_read | data_write}, 128'd0);
        end else begin
          r = req_q.pop_front();
          chk("req_kind", {126'b0, data_read, data_write}, {126'b0, !r.wr, r.wr});
          chk("req_addr", {96'b0, data_addr}, {96'b0, r.addr});
          chk("req_mbe", {124'b0, data_mbe}, {124'b0, r.mbe});
          chk("req_wdata", {96'b0, data_wdata}, {96'b0, r.wdata});
        end
        held = {57'b0, data_read, data_write, in_ready, data_addr, data_mbe, data_wdata};
        d = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 3));
        repeat (d) begin
          @(posedge clk); #2;
          chk("req_stable", {57'b0, data_read, data_write, in_ready, data_addr, data_mbe, data_wdata}, held);
        end
        b = {data_addr[7:2], 2'b00};
        data_rdata = {mem_b[b + 8'd3], mem_b[b + 8'd2], mem_b[b + 8'd1], mem_b[b]};
        data_resp = 1'b1;
        @(posedge clk); #2;
        data_resp = 1'b0; data_rdata = $urandom;
        chk("resp_complete", {124'b0, data_read, data_write, in_ready, wb_valid}, 128'b0011);
      end
    end
  end

  // Monitor: every writeback record must match the oldest expectation.
  always @(negedge clk) begin
    wb_t e;
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", {96'b0, wb_data}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", {123'b0, wb_rd}, {123'b0, e.rd});
          chk("wb_data", {96'b0, wb_data}, {96'b0, e.data});
          chk("wb_misalign", {127'b0, misalign}, {127'b0, e.mis});
        end
      end else begin
        chk("misalign_idle", {127'b0, misalign}, 128'd0);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    rst_n = 1'b0; ex_valid = 1'b1; flush = 1'b0; ex_op = 2'b01; ex_funct3 = 3'b010;
    ex_alu_out = 32'h1000; ex_rs2 = '0; ex_rd = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {124'b0, data_read, data_write, wb_valid, misalign}, 128'd0);
    chk("reset_data", {27'b0, data_addr, data_mbe, data_wdata, wb_rd, wb_data}, 128'd0);
    chk("reset_in_ready", {127'b0, in_ready}, 128'd1);
    ex_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", {126'b0, in_ready, wb_valid}, 128'b10);

    // ALU stream, back to back
    for (int i = 0; i < 3; i++) begin
      chk("alu_in_ready", {127'b0, in_ready}, 128'd1);
      issue(2'b00, 3'b000, 32'h11 * (i + 1), 32'h0, 5'(5 + i), 1'b0);
    end

    // LB / LBU at 0x1003 against word 0x80FF_0000
    mem_b[0] = 8'h00; mem_b[1] = 8'h00; mem_b[2] = 8'hFF; mem_b[3] = 8'h80;
    resp_delay = 3;
    issue(2'b01, 3'b000, 32'h1003, 32'h0, 5'd10, 1'b0);
    issue(2'b01, 3'b100, 32'h1003, 32'h0, 5'd11, 1'b0);
    // SH at 0x2002
    issue(2'b10, 3'b001, 32'h2002, 32'h0000_BEEF, 5'd12, 1'b0);
    resp_delay = 0;
    issue(2'b01, 3'b001, 32'h2002, 32'h0, 5'd13, 1'b0);
    issue(2'b01, 3'b101, 32'h2002, 32'h0, 5'd14, 1'b0);

    // Misaligned LW then immediate ALU op
    issue(2'b01, 3'b010, 32'h3001, 32'h0, 5'd15, 1'b0);
    issue(2'b00, 3'b000, 32'h44, 32'h0, 5'd16, 1'b0);

    // Flush in IDLE, then flush while BUSY
    issue(2'b01, 3'b010, 32'h1020, 32'h0, 5'd17, 1'b1);
    resp_delay = 3;
    issue(2'b01, 3'b010, 32'h1040, 32'h0, 5'd18, 1'b0);
    ex_valid = 1'b1; flush = 1'b1; ex_op = 2'b00; ex_rd = 5'd9; ex_alu_out = 32'h99;
    repeat (2) begin @(posedge clk); #1; end
    ex_valid = 1'b0; flush = 1'b0;

    // Reset while BUSY, then a stray response
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    auto_resp = 0;
    issue(2'b01, 3'b010, 32'h1050, 32'h0, 5'd19, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy_drop", {125'b0, data_read, data_write, in_ready}, 128'b001);
    rst_n = 1'b1;
    exp_q.delete(); req_q.delete();
    @(posedge clk); #1;
    data_resp = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_resp = 1'b0;
    chk("stray_resp_ignored", {125'b0, wb_valid, data_read, in_ready}, 128'b001);
    auto_resp = 1;

    // Randomized mix
    resp_delay = -1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      a  = (op == 2'b01 || op == 2'b10) ? (32'h1000 | 32'($urandom_range(0, 255))) : $urandom;
      issue(op, 3'($urandom), a, $urandom, 5'($urandom), ($urandom_range(0, 7) == 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 128'(exp_q.size() + req_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
